// File: rtl/pe_pkg.sv
// Shared types and constants for the PE convolution responder.
package pe_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_ACC_W  = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic SEL_MAC  = 1'b0;
    localparam logic SEL_EMIT = 1'b1;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] filter_addr;
        logic [DEF_ADDR_W-1:0] ifmap_addr;
        logic                  acc_clear;
        logic                  sel;
        logic                  done;
    } cmd_t;

endpackage

// File: rtl/pe_conv_responder_if.sv
// Command, load, psum and done channels between the PE sequencer and the responder.
interface pe_conv_responder_if
    import pe_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_filter_addr;
    logic [ADDR_W-1:0] cmd_ifmap_addr;
    logic              cmd_acc_clear;
    logic              cmd_sel;
    logic              cmd_done;

    logic              ld_valid;
    logic              ld_ready;
    logic              ld_sel;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    logic              psum_valid;
    logic              psum_ready;
    logic [ACC_W-1:0]  psum_data;
    logic [ADDR_W-1:0] psum_idx;

    logic              done_valid;
    logic              done_ready;

    logic              err;

    modport master (
        output cmd_valid, cmd_filter_addr, cmd_ifmap_addr, cmd_acc_clear, cmd_sel, cmd_done,
        output ld_valid, ld_sel, ld_addr, ld_data,
        output psum_ready, done_ready,
        input  cmd_ready, ld_ready, psum_valid, psum_data, psum_idx, done_valid, err
    );

    modport slave (
        input  cmd_valid, cmd_filter_addr, cmd_ifmap_addr, cmd_acc_clear, cmd_sel, cmd_done,
        input  ld_valid, ld_sel, ld_addr, ld_data,
        input  psum_ready, done_ready,
        output cmd_ready, ld_ready, psum_valid, psum_data, psum_idx, done_valid, err
    );

endinterface

// File: rtl/pe_regfile.sv
// Small register file: one synchronous write, one combinational read, range flags.
// Out-of-range reads return 0 and out-of-range writes are dropped.
module pe_regfile #(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_oob,
    output logic              wr_oob
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_oob = (rd_addr >= ADDR_W'(DEPTH));
    assign wr_oob = wr_en && (wr_addr >= ADDR_W'(DEPTH));

    // Write the addressed entry when in range; reset clears every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && !wr_oob) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    // Decode the read address; anything past the depth reads as 0.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/pe_conv_responder.sv
// Far-end responder of the PE control stream: MACs filter x ifmap entries into an
// accumulator, hands partial sums downstream, then signals frame completion.
module pe_conv_responder
    import pe_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FILT_LEN  = 3,
    parameter int IFMAP_LEN = 5,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int ACC_W     = DEF_ACC_W
) (
    input logic               clk,
    input logic               rst_n,
    pe_conv_responder_if.slave bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_EMIT = EMIT;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]          state;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    psum_data_reg;
    logic [ADDR_W-1:0]   psum_idx_reg;
    logic [ADDR_W-1:0]   count;
    logic                psum_valid_reg;
    logic                done_valid_reg;
    logic                err_reg;

    logic                idle;
    logic                cmd_fire;
    logic                mac_fire;
    logic                emit_fire;
    logic                done_fire;
    logic                ld_fire;
    logic                filt_wr_en;
    logic                ifmap_wr_en;

    logic [DATA_W-1:0]   filt_rd;
    logic [DATA_W-1:0]   ifmap_rd;
    logic                filt_rd_oob;
    logic                ifmap_rd_oob;
    logic                filt_wr_oob;
    logic                ifmap_wr_oob;

    logic [2*DATA_W-1:0] product;
    logic [ACC_W-1:0]    acc_base;

    assign idle      = (state == ST_IDLE);
    assign cmd_fire  = bus.cmd_valid && idle;
    assign done_fire = cmd_fire && bus.cmd_done;
    assign mac_fire  = cmd_fire && !bus.cmd_done && (bus.cmd_sel == SEL_MAC);
    assign emit_fire = cmd_fire && !bus.cmd_done && (bus.cmd_sel == SEL_EMIT);

    assign ld_fire     = bus.ld_valid && idle;
    assign filt_wr_en  = ld_fire && !bus.ld_sel;
    assign ifmap_wr_en = ld_fire && bus.ld_sel;

    // Reads are combinational, so a MAC sees the contents from before a same-cycle load.
    assign product  = filt_rd * ifmap_rd;
    assign acc_base = bus.cmd_acc_clear ? '0 : acc;

    assign bus.cmd_ready  = idle;
    assign bus.ld_ready   = idle;
    assign bus.psum_valid = psum_valid_reg;
    assign bus.psum_data  = psum_data_reg;
    assign bus.psum_idx   = psum_idx_reg;
    assign bus.done_valid = done_valid_reg;
    assign bus.err        = err_reg;

    pe_regfile #(
        .DEPTH  (FILT_LEN),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (filt_wr_en),
        .wr_addr (bus.ld_addr),
        .wr_data (bus.ld_data),
        .rd_addr (bus.cmd_filter_addr),
        .rd_data (filt_rd),
        .rd_oob  (filt_rd_oob),
        .wr_oob  (filt_wr_oob)
    );

    pe_regfile #(
        .DEPTH  (IFMAP_LEN),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ifmap (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ifmap_wr_en),
        .wr_addr (bus.ld_addr),
        .wr_data (bus.ld_data),
        .rd_addr (bus.cmd_ifmap_addr),
        .rd_data (ifmap_rd),
        .rd_oob  (ifmap_rd_oob),
        .wr_oob  (ifmap_wr_oob)
    );

    // Command FSM: MACs stay in IDLE, emit and done park until their handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            acc            <= '0;
            psum_data_reg  <= '0;
            psum_idx_reg   <= '0;
            count          <= '0;
            psum_valid_reg <= 1'b0;
            done_valid_reg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (done_fire) begin
                        done_valid_reg <= 1'b1;
                        state          <= ST_DONE;
                    end else if (mac_fire) begin
                        acc <= acc_base + ACC_W'(product);
                    end else if (emit_fire) begin
                        psum_data_reg  <= acc;
                        psum_idx_reg   <= count;
                        psum_valid_reg <= 1'b1;
                        state          <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.psum_ready) begin
                        psum_valid_reg <= 1'b0;
                        count          <= count + 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (bus.done_ready) begin
                        done_valid_reg <= 1'b0;
                        count          <= '0;
                        acc            <= '0;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error on any out-of-range MAC operand or dropped load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if ((mac_fire && (filt_rd_oob || ifmap_rd_oob)) || filt_wr_oob || ifmap_wr_oob) begin
            err_reg <= 1'b1;
        end
    end

endmodule

// File: doc/pe_conv_responder.md
Name: pe_conv_responder

Overview:
- Clocked responder on the far end of the PE control stream: executes filter/ifmap address commands, multiply-accumulates, emits partial sums, then signals frame done.
- Holds local filter and ifmap register files, loaded over a write port.
- Sits between the PE control sequencer (command initiator) and the downstream psum consumer / frame-done logic of the SNN PE.

Parameters:
- DATA_W, 8, width of filter weights and ifmap values (unsigned)
- FILT_LEN, 3, filter register file depth
- IFMAP_LEN, 5, ifmap register file depth
- ADDR_W, 8, command/load address width
- ACC_W, 20, accumulator and psum width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both valid and ready are high at a rising edge
- cmd_filter_addr  in  ADDR_W  filter index
- cmd_ifmap_addr  in  ADDR_W  ifmap index
- cmd_acc_clear  in  1  start accumulation from 0
- cmd_sel  in  1  0 = MAC, 1 = emit psum
- cmd_done  in  1  end-of-frame marker (overrides cmd_sel)
- ld_valid  in  1  load write strobe
- ld_ready  out  1  load accepted
- ld_sel  in  1  0 = filter file, 1 = ifmap file
- ld_addr  in  ADDR_W  load index
- ld_data  in  DATA_W  load value
- psum_valid  out  1  psum offered
- psum_ready  in  1  downstream accepts psum
- psum_data  out  ACC_W  accumulated partial sum
- psum_idx  out  ADDR_W  output position within the frame
- done_valid  out  1  frame complete
- done_ready  in  1  done accepted
- err  out  1  sticky out-of-range flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc, psum_data, psum_idx, psum count = 0; psum_valid, done_valid, err = 0; both register files cleared to 0.
- The ready outputs are combinational from state: cmd_ready = ld_ready = (state==IDLE).
- FSM states: IDLE, EMIT, DONE.
- IDLE, MAC command (cmd_done=0, cmd_sel=0):
  - acc <= (cmd_acc_clear ? 0 : acc) + W[filter_addr]*X[ifmap_addr].
  - The product is truncated (wraps modulo 2^ACC_W); the command completes in a single cycle.
- IDLE, emit command (cmd_done=0, cmd_sel=1):
  - psum_data <= acc, psum_idx <= count, psum_valid <= 1, state -> EMIT.
  - acc is unchanged; cmd_acc_clear is ignored.
- IDLE, done command (cmd_done=1):
  - All other fields are ignored, including filter_addr all-ones; no MAC is performed.
  - done_valid <= 1, state -> DONE.
- EMIT: cmd_ready=0. On psum_valid&&psum_ready: psum_valid <= 0, count <= count+1, state -> IDLE. psum_data and psum_idx stay stable while valid is high.
- DONE: cmd_ready=0. On done_valid&&done_ready: done_valid <= 0, count <= 0, acc <= 0, state -> IDLE.
- Load: in IDLE, ld_valid writes ld_data to the file selected by ld_sel.
  - If a load and a MAC command land in the same cycle, the MAC reads the pre-write contents.
- Out of range (filter_addr >= FILT_LEN or ifmap_addr >= IFMAP_LEN on a MAC): that operand reads as 0 and err <= 1.
  - A load with ld_addr past the selected depth is dropped and sets err <= 1.
  - err clears only on reset.
- count wraps modulo 2^ADDR_W.
- Reset asserted mid-EMIT or mid-DONE: valids drop immediately, with no handshake completion.
- Latency:
  - MAC result is visible in acc one edge after acceptance.
  - psum_valid rises one edge after an emit command is accepted.
  - Back-to-back commands are accepted every cycle while in IDLE.

Decomposition:
- Shared package pe_pkg: state enum (IDLE/EMIT/DONE), cmd_sel encodings (SEL_MAC=0, SEL_EMIT=1), default DATA_W/ACC_W constants, and a command struct typedef (filter_addr, ifmap_addr, acc_clear, sel, done).
- One natural sub-module, pe_regfile: depth/width-parameterised register file with one synchronous write, one combinational read, and an out-of-range flag. Instantiate it twice, once for filter and once for ifmap.

Test Plan:
- Load filter [1,2,3] and ifmap [1,0,1,1,0]. Run control pattern i=0..2: MACs j=0..2 with clear on j=0, then emit. Done after all three -> psum 4,5,3 with idx 0,1,2, then done_valid.
- Hold psum_ready=0 for 5 cycles during EMIT -> psum_data/idx stable, cmd_ready=0, next command not consumed. Release -> single transfer.
- Load to ifmap[2]=7 in the same cycle as a MAC reading ifmap[2] (old value 1, W=2) -> acc gains 2. A following MAC on the same address gains 14.
- MAC with filter_addr=3 (FILT_LEN=3) -> product 0, err=1 and sticky. Done command with filter_addr=8'hFF -> no err change, done_valid=1.
- W=255, X=255, 20 MACs without clear -> acc = 20*65025 mod 2^20 = 251924.
- Assert rst_n during EMIT -> psum_valid, acc, count and err immediately 0; state IDLE; cmd_ready=1 after release.
